// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM_Controller port: registers the
// winning request, holds the enables until sram_ready, then pulses the owner's ack.
module sram_arbiter #(
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [63:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [63:0] p1_rdata,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_grant, last_grant_n;
  logic [1:0]    grant_n;
  logic          read_en_n, write_en_n;
  logic [31:0]   addr_n, wdata_n;
  logic [63:0]   p0_rdata_n, p1_rdata_n;
  logic          p0_ack_n, p1_ack_n;
  logic          timeout_err_n;
  logic          win, win_we;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      grant         <= '0;
      sram_read_en  <= 1'b0;
      sram_write_en <= 1'b0;
      sram_address  <= '0;
      sram_wdata    <= '0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      last_grant    <= last_grant_n;
      grant         <= grant_n;
      sram_read_en  <= read_en_n;
      sram_write_en <= write_en_n;
      sram_address  <= addr_n;
      sram_wdata    <= wdata_n;
      p0_rdata      <= p0_rdata_n;
      p1_rdata      <= p1_rdata_n;
      p0_ack        <= p0_ack_n;
      p1_ack        <= p1_ack_n;
      timeout_err   <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_grant_n  = last_grant;
    grant_n       = grant;
    read_en_n     = sram_read_en;
    write_en_n    = sram_write_en;
    addr_n        = sram_address;
    wdata_n       = sram_wdata;
    p0_rdata_n    = p0_rdata;
    p1_rdata_n    = p1_rdata;
    p0_ack_n      = 1'b0;
    p1_ack_n      = 1'b0;
    timeout_err_n = timeout_err;
    win           = 1'b0;
    win_we        = 1'b0;

    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          // win = 1 selects port 1; ties go opposite last_grant only in round-robin mode
          if (p0_req && p1_req) win = (RR_MODE != 0) ? ~last_grant : 1'b0;
          else                  win = p1_req;
          win_we       = win ? p1_we : p0_we;
          last_grant_n = win;
          grant_n      = win ? 2'b10 : 2'b01;
          addr_n       = win ? p1_addr : p0_addr;
          wdata_n      = win ? p1_wdata : p0_wdata;
          write_en_n   = win_we;
          read_en_n    = ~win_we;
          cnt_n        = '0;
          state_n      = ACCESS;
        end
      end
      ACCESS: begin
        if (sram_ready) begin
          read_en_n  = 1'b0;
          write_en_n = 1'b0;
          if (sram_read_en) begin
            if (grant[1]) p1_rdata_n = sram_rdata;
            else          p0_rdata_n = sram_rdata;
          end
          p0_ack_n = grant[0];
          p1_ack_n = grant[1];
          state_n  = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          read_en_n     = 1'b0;
          write_en_n    = 1'b0;
          timeout_err_n = 1'b1;
          p0_ack_n      = grant[0];
          p1_ack_n      = grant[1];
          state_n       = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM_Controller port between two requesters: port 0 (data-side Cache_Controller) and port 1 (instruction-side fetch/refill).
- Arbitrates, registers the winning request, drives sram_read_en/sram_write_en until sram_ready, then returns read data with a one-cycle ack.
- Includes a per-access watchdog.

Parameters:
- RR_MODE, 1, 1 = round-robin between ports on simultaneous requests; 0 = fixed priority, port 0 wins.
- TIMEOUT, 64, max cycles in ACCESS before abort; counter width = clog2(TIMEOUT)+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 request; held until p0_ack
- p0_we  input  1  port 0: 1 = write, 0 = read
- p0_addr  input  32  port 0 byte address
- p0_wdata  input  32  port 0 write data
- p0_ack  output  1  port 0 completion pulse, one cycle
- p0_rdata  output  64  port 0 read data, valid with p0_ack on reads
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- sram_read_en  output  1  read enable to SRAM_Controller
- sram_write_en  output  1  write enable to SRAM_Controller
- sram_address  output  32  address to SRAM_Controller
- sram_wdata  output  32  write data to SRAM_Controller
- sram_rdata  input  64  read data from SRAM_Controller
- sram_ready  input  1  controller status (see Behaviour)
- grant  output  2  one-hot owner of the current access; 00 when IDLE
- busy  output  1  1 in ACCESS or DONE
- timeout_err  output  1  sticky; set on watchdog abort, cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0 (acks, enables, address, wdata, rdata regs, grant, busy, timeout_err); last_grant=port 1, so port 0 wins the first tie.
- Reset mid-access aborts with no ack; enables low after that edge.
- SRAM_Controller contract: with an enable held, sram_ready=0 while the access is in progress and 1 in the completion cycle; sram_rdata is valid in that cycle. Enables must stay stable until then. sram_ready is ignored in IDLE and DONE.
- IDLE state:
  - Sample requests each cycle.
  - Single request: grant that port.
  - Both requesting: RR_MODE=1 grants the port opposite last_grant; RR_MODE=0 grants port 0.
  - On grant, at the same edge: latch addr/wdata/we into sram_address/sram_wdata, assert sram_write_en=we or sram_read_en=~we, set grant, update last_grant, clear watchdog counter, go to ACCESS.
  - Enables are registered: request seen at edge t gives enables high at t+1.
- ACCESS state:
  - Hold enables and payload; increment counter each cycle.
  - sram_ready=1: capture sram_rdata into the granted port's rdata register (reads only; writes leave it unchanged), drop enables, assert that port's ack, go to DONE.
  - Counter reaches TIMEOUT-1 with sram_ready=0: drop enables, set timeout_err, assert ack, leave rdata unchanged, go to DONE.
- DONE state (one cycle):
  - ack high; grant still shows the owner; requests not sampled, so the requester drops req this cycle.
  - Next edge: ack=0, grant=00, go to IDLE.
  - The earliest next grant is sampled in the first IDLE cycle.
- Latency: req at edge t, completion seen at edge c, ack high during cycle c to c+1. Minimum with a 1-cycle controller: ack 2 cycles after req.
- Request changes while not granted are harmless. Changes to the granted port's payload after grant are ignored.
- An ack is never issued to a port that was not granted; p0_ack and p1_ack are never high together.
- busy = (state != IDLE).

Test Plan:
- Single read: p0_req=1, we=0, addr=0x0000_0400; controller returns ready 3 cycles after enable with rdata=0x1122_3344_5566_7788 -> sram_read_en high for exactly 3 cycles; p0_ack one cycle; p0_rdata=0x1122334455667788; grant=01 throughout; p1_ack=0.
- Simultaneous requests, RR_MODE=1: both req from reset; p0 write 0xDEADBEEF @0x10, p1 read @0x20 -> p0 served first (sram_write_en, wdata=0xDEADBEEF), then p1 (sram_read_en, addr=0x20); acks in order p0, p1. With both requests held, grants alternate 01,10,01,10 over 4 accesses.
- Fixed priority, RR_MODE=0: p0 and p1 requesting continuously, p0 re-requests immediately after each ack -> p1 granted only when p0_req=0; no p1_ack while p0 keeps requesting.
- Watchdog: TIMEOUT=8, sram_ready stuck 0 after p1 read -> enable high exactly 8 cycles, then p1_ack, timeout_err=1 (sticky across later good accesses), p1_rdata unchanged.
- Reset mid-access: rst=1 in the 2nd ACCESS cycle of a p0 write -> next edge: enables 0, grant 00, busy 0, no p0_ack. After rst release, a pending p0_req is regranted from IDLE.
- Back-to-back: p1 drops req during ack, p0 requesting -> p0 enable rises exactly 2 edges after p1_ack rose; no overlap of enables.
